neuron_mac_sequencer: RTL and testbench
=======================================

Name: neuron_mac_sequencer

Overview:
- Downstream consumer of the weight RAM: reads one neuron's weight vector N words at a time and multiplies each group against an incoming feature group.
- Accumulates a signed dot product across NUM_GROUPS groups and presents it with a one-cycle Done pulse.
- Drives the RAM Address port in read mode only. The parent ties RAM WE=0 while this block is Busy. RAM read latency is one clock (Q registered on the posedge after Address is stable).

Parameters:
- N, 10, lanes per group; must equal the weight RAM's N.
- NUM_GROUPS, 6, groups per neuron; N*NUM_GROUPS must be ≤ 65.
- DW, 10, weight/feature width, signed two's complement.
- ACC_W, 26, accumulator/Sum width; must be ≥ 2*DW+ceil(log2(N*NUM_GROUPS)).

Ports:
- Clock  in  1  sole clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  begin one dot product; sampled only in IDLE.
- X  in  [DW-1:0] x N (unpacked [0:N-1])  feature group, signed.
- X_Valid  in  1  X holds a valid group.
- X_Ready  out  1  block accepts X this cycle.
- Q  in  [DW-1:0] x N (unpacked [0:N-1])  weight words from RAM.
- Address  out  7  RAM base address, registered.
- Busy  out  1  high in every state except IDLE.
- Sum  out  ACC_W  signed result; holds until the next Done.
- Done  out  1  one-cycle pulse; Sum is valid in the same cycle.

Behaviour:
- Reset (Rst=1 at posedge, any state): State=IDLE, Address=0, group counter g=0, Acc=0, Sum=0. Done, X_Ready and Busy are all 0. Reset mid-operation aborts the run with no Done pulse.
- IDLE:
  - Start=1 → g<=0, Acc<=0, Address<=0, go to FETCH.
  - Start=0 → stay in IDLE.
- FETCH: Address is stable, X_Ready=0. Unconditionally go to LOAD; the RAM captures Q at this edge.
- LOAD: Q is valid and X_Ready=1. A handshake occurs when X_Valid=1 at the posedge.
  - Group sum = sum over i of sext(Q[i])*sext(X[i]). Each product is 2*DW bits signed; all terms are summed at ACC_W bits.
  - On handshake with g<NUM_GROUPS-1: Acc<=Acc+group sum, g<=g+1, Address<=(g+1)*N, go to FETCH.
  - On handshake with g==NUM_GROUPS-1: Sum<=Acc+group sum, go to DONE.
  - No handshake: stay in LOAD; Address and Acc are held. The RAM re-reads the same address, so Q stays stable.
- DONE: Done=1 and Busy=1 for exactly one cycle, then go to IDLE. Start is ignored in DONE and in all busy states; it is not queued.
- Latency: Start is sampled at edge E. With X_Valid held high, Done is high in cycle E+2*NUM_GROUPS+1 (13 cycles for the defaults). Each LOAD cycle with X_Valid=0 adds exactly one cycle.
- Address sequence: 0, N, 2N, … (NUM_GROUPS-1)*N. Address never exceeds (NUM_GROUPS-1)*N and holds its last value through DONE/IDLE until the next Start. Widen Address arithmetic internally so it never wraps.
- Overflow: none possible given the ACC_W rule; no saturation logic.
- X_Ready is combinational from state only (LOAD). It never depends on X_Valid.

Test Plan:
- Preload all 60 weights = 1, X all = 2, X_Valid held high, pulse Start → Address 0,10,20,30,40,50 in successive FETCH cycles; Done at Start-edge+13; Sum=120.
- Weights all 10'h3FF (−1), X all = 3 → Sum=−180 (26'h3FFFF4C), Done after 13 cycles.
- Extremes: weights and X all 10'h200 (−512) → Sum=15,728,640. No overflow; sign correct.
- Stall: drop X_Valid for 5 cycles in LOAD of group 2 → X_Ready stays 1; Address holds 20; Done delayed by exactly 5 cycles; Sum unchanged vs. the no-stall run.
- Rst asserted in group 3 LOAD → next cycle Busy=0, Sum=0, Address=0, no Done. Re-Start gives the correct result with full latency.
- Start pulsed while Busy and during DONE → ignored: exactly one Done and Busy drops. A Start one cycle after Done begins a new run.

Source files
------------

// File: rtl/neuron_mac_sequencer.sv
// Weight-RAM reader that accumulates a signed dot product of NUM_GROUPS
// N-lane weight groups against incoming feature groups, then pulses Done.
module neuron_mac_sequencer #(
  parameter int N          = 10,
  parameter int NUM_GROUPS = 6,
  parameter int DW         = 10,
  parameter int ACC_W      = 26
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             Start,
  input  logic [DW-1:0]    X [0:N-1],
  input  logic             X_Valid,
  output logic             X_Ready,
  input  logic [DW-1:0]    Q [0:N-1],
  output logic [6:0]       Address,
  output logic             Busy,
  output logic [ACC_W-1:0] Sum,
  output logic             Done
);

  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int PW = 2 * DW;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, DONE} state_t;

  state_t                  state, state_nxt;
  logic [GW-1:0]           g;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] group_sum;
  logic                    handshake;
  logic                    last_group;

  function automatic logic signed [ACC_W-1:0] mac_term(input logic [DW-1:0] q,
                                                       input logic [DW-1:0] x);
    logic signed [PW-1:0] qe;
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] prod;
    qe   = {{DW{q[DW-1]}}, q};
    xe   = {{DW{x[DW-1]}}, x};
    prod = qe * xe;
    return {{(ACC_W-PW){prod[PW-1]}}, prod};
  endfunction

  always_comb begin
    group_sum = '0;
    for (int i = 0; i < N; i++) begin
      group_sum = group_sum + mac_term(Q[i], X[i]);
    end
  end

  assign last_group = (g == GW'(NUM_GROUPS - 1));

  always_ff @(posedge Clock) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    X_Ready   = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) state_nxt = FETCH;
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        X_Ready   = 1'b1;
        handshake = X_Valid;
        if (X_Valid) state_nxt = last_group ? DONE : FETCH;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulate stage: RAM output and feature group combine on the LOAD handshake
  always_ff @(posedge Clock) begin
    if (Rst) begin
      g       <= '0;
      acc     <= '0;
      Address <= '0;
      Sum     <= '0;
    end else if (state == IDLE && Start) begin
      g       <= '0;
      acc     <= '0;
      Address <= '0;
    end else if (handshake) begin
      if (last_group) begin
        Sum <= acc + group_sum;
      end else begin
        acc     <= acc + group_sum;
        g       <= g + 1'b1;
        // int arithmetic keeps the base-address product from wrapping
        Address <= 7'((int'(g) + 1) * N);
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer: behavioural one-cycle weight RAM,
// constant feature groups, hand-computed sums and latencies.
module tb_neuron_mac_sequencer;

  localparam int N          = 10;
  localparam int NUM_GROUPS = 6;
  localparam int DW         = 10;
  localparam int ACC_W      = 26;

  logic             Clock;
  logic             Rst;
  logic             Start;
  logic [DW-1:0]    X [0:N-1];
  logic             X_Valid;
  logic             X_Ready;
  logic [DW-1:0]    Q [0:N-1];
  logic [6:0]       Address;
  logic             Busy;
  logic [ACC_W-1:0] Sum;
  logic             Done;

  logic [DW-1:0]    wmem [0:127];

  int tests_run;
  int tests_failed;

  neuron_mac_sequencer #(
    .N(N), .NUM_GROUPS(NUM_GROUPS), .DW(DW), .ACC_W(ACC_W)
  ) dut (
    .Clock(Clock), .Rst(Rst), .Start(Start), .X(X), .X_Valid(X_Valid),
    .X_Ready(X_Ready), .Q(Q), .Address(Address), .Busy(Busy), .Sum(Sum),
    .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Weight RAM: Q registered one clock after Address
  always @(posedge Clock) begin
    for (int i = 0; i < N; i++) Q[i] <= wmem[int'(Address) + i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_vectors(input logic [DW-1:0] w, input logic [DW-1:0] x);
    for (int k = 0; k < 128; k++) wmem[k] = w;
    for (int i = 0; i < N; i++) X[i] = x;
  endtask

  // One dot-product run. stall_grp/stall_n insert X_Valid=0 cycles in that
  // group's LOAD; abort_grp asserts Rst in that group's LOAD; poke toggles
  // Start while busy. Returns cycles from the Start-sampling edge to Done.
  task automatic run(input int stall_grp, input int stall_n, input int abort_grp,
                     input bit poke, output int cycles, output bit done_seen);
    int grp;
    int stall_left;
    int fetch_idx;
    bit aborting;
    grp        = 0;
    stall_left = stall_n;
    fetch_idx  = 0;
    aborting   = 1'b0;
    cycles     = 0;
    done_seen  = 1'b0;
    Start      = 1'b1;
    X_Valid    = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge Clock);
      #1;
      Start = 1'b0;
      cycles++;
      if (aborting) begin
        Rst = 1'b0;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_sum", 32'(Sum), 32'd0);
        check("abort_addr", 32'(Address), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        return;
      end
      if (Done) begin
        done_seen = 1'b1;
        return;
      end
      if (poke) Start = (c % 2 == 0);
      if (Busy && !X_Ready && fetch_idx < NUM_GROUPS) begin
        check($sformatf("fetch_addr%0d", fetch_idx), 32'(Address), 32'(fetch_idx * N));
        fetch_idx++;
      end
      if (X_Ready) begin
        if (grp == abort_grp) begin
          Rst      = 1'b1;
          aborting = 1'b1;
        end else if (grp == stall_grp && stall_left > 0) begin
          X_Valid = 1'b0;
          stall_left--;
          check("stall_addr", 32'(Address), 32'(grp * N));
        end else begin
          X_Valid = 1'b1;
          grp++;
        end
      end
    end
    check("run_timeout", 32'd1, 32'd0);
  endtask

  task automatic full_run(input string tag, input int stall_grp, input int stall_n,
                          input logic [31:0] exp_sum, input int exp_cycles);
    int cyc;
    bit dn;
    run(stall_grp, stall_n, -1, 1'b0, cyc, dn);
    check({tag, "_done"}, 32'(dn), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cycles));
    check({tag, "_sum"}, 32'(Sum), exp_sum);
    check({tag, "_busy_in_done"}, 32'(Busy), 32'd1);
    @(posedge Clock);
    #1;
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
    check({tag, "_idle"}, 32'(Busy), 32'd0);
    check({tag, "_addr_hold"}, 32'(Address), 32'(N * (NUM_GROUPS - 1)));
  endtask

  initial begin
    int cyc;
    bit dn;
    int extra_done;
    tests_run    = 0;
    tests_failed = 0;
    Rst          = 1'b1;
    Start        = 1'b0;
    X_Valid      = 1'b0;
    load_vectors(10'd0, 10'd0);
    repeat (2) @(posedge Clock);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_xready", 32'(X_Ready), 32'd0);
    check("rst_sum", 32'(Sum), 32'd0);
    check("rst_addr", 32'(Address), 32'd0);
    Rst = 1'b0;
    @(posedge Clock);
    #1;

    // 60 * (1*2) = 120
    load_vectors(10'd1, 10'd2);
    full_run("ones", -1, 0, 32'd120, 13);

    // 60 * (-1*3) = -180
    load_vectors(10'h3FF, 10'd3);
    full_run("neg", -1, 0, 32'h03FF_FF4C, 13);

    // 60 * (-512*-512) = 15,728,640
    load_vectors(10'h200, 10'h200);
    full_run("extreme", -1, 0, 32'd15728640, 13);

    load_vectors(10'd1, 10'd2);
    full_run("stall", 2, 5, 32'd120, 18);

    run(-1, 0, 3, 1'b0, cyc, dn);
    check("abort_no_done", 32'(dn), 32'd0);
    full_run("restart", -1, 0, 32'd120, 13);

    // Start toggled while busy, and held high in the DONE cycle
    load_vectors(10'd3, 10'd2);
    run(-1, 0, -1, 1'b1, cyc, dn);
    check("poke_done", 32'(dn), 32'd1);
    check("poke_latency", 32'(cyc), 32'd13);
    check("poke_sum", 32'(Sum), 32'd360);
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    check("poke_after_busy", 32'(Busy), 32'd0);
    extra_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clock);
      #1;
      if (Done || Busy) extra_done++;
    end
    check("poke_no_requeue", 32'(extra_done), 32'd0);

    load_vectors(10'd2, 10'h3FE);
    full_run("after_poke", -1, 0, 32'h03FF_FF10, 13);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
